// File: rtl/adder_share_arb.sv
// Round-robin sharing of one external 32-bit adder among NREQ requesters.
// Optional ADDER_CHECK_EN: sticky err when the adder result disagrees with a behavioural sum.
module adder_share_arb #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_s,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 err
);
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_next;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_a, r_b, r_sum;
    logic            r_cin, r_cout, r_rsp_valid;
    logic [IDW-1:0]  r_id;

    logic            w_found;
    logic [IDW-1:0]  w_gnt;
    logic [IDW:0]    w_idx;
    logic [NREQ-1:0] w_ready;
    logic [31:0]     w_sel_a, w_sel_b;
    logic            w_sel_cin;
    logic            w_take, w_done, w_fire;

    // Descending scan so the requester closest to r_ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_sel_a   = req_a[32*i +: 32];
                w_sel_b   = req_b[32*i +: 32];
                w_sel_cin = req_cin[i];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_found)
            w_ready[w_gnt] = 1'b1;
    end

    assign w_take = (r_state == S_IDLE) && w_found;
    assign w_done = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_fire = r_rsp_valid && rsp_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_next = S_WAIT;
            S_WAIT:  if (w_done) w_next = S_RESP;
            S_RESP:  if (w_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_take) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_cin <= w_sel_cin;
                r_id  <= w_gnt;
                r_cnt <= CW'(ADD_LAT-1);
            end
            if (w_done) begin
                r_sum       <= add_s;
                r_cout      <= add_cout;
                r_rsp_valid <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Pointer moves past the served requester only once its response is taken.
            if (w_fire) begin
                r_rsp_valid <= 1'b0;
                r_ptr       <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
            end
        end
    end

`ifdef ADDER_CHECK_EN
    logic [32:0] w_ref;
    logic        r_err;
    assign w_ref = {1'b0, r_a} + {1'b0, r_b} + {32'd0, r_cin};
    always_ff @(posedge clk) begin
        if (!rst_n)                                     r_err <= 1'b0;
        else if (w_done && ({add_cout, add_s} != w_ref)) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign req_ready = w_ready;
    assign add_a     = r_a;
    assign add_b     = r_b;
    assign add_cin   = r_cin;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
endmodule
